axi4_stream_rr_arbiter: RTL
===========================

Name: axi4_stream_rr_arbiter

Overview:
- Packet-level round-robin arbiter that shares one AXI4-Stream output among SRC_CNT AXI4-Stream requesters.
- Grant is locked from the first beat of a packet until its tlast handshake, so packets are never interleaved.
- Sits in front of width converters and other single-stream consumers, so several producers can feed one datapath.
- Runtime mask input lets control logic enable or disable individual sources.

Parameters:
- SRC_CNT, 4, number of slave streams; legal range 2..16.
- TDATA_WIDTH, 64, tdata width of all streams, multiple of 8.
- TID_WIDTH, 1, tid width.
- TDEST_WIDTH, 1, tdest width.
- TUSER_WIDTH, 1, tuser width.

Ports:
- clk_i  input  1  single clock for the whole block.
- rst_i  input  1  reset, synchronous, active-low.
- src_en_i  input  SRC_CNT  per-source arbitration enable mask.
- pkt_i  slave axi4_stream_if array  SRC_CNT  requester streams, each TDATA_WIDTH bits.
- pkt_o  master axi4_stream_if  TDATA_WIDTH  arbitrated output stream.
- grant_idx_o  output  SRC_CNT_W  index of the current owner.
- busy_o  output  1  a packet is currently granted.

Behaviour:
- SRC_CNT_W = max(1, $clog2(SRC_CNT)).
- A source requests when pkt_i[k].tvalid && src_en_i[k].
- State machine has two states: IDLE and BUSY.
- Reset (rst_i low at a clk_i edge):
  - state=IDLE, grant_idx_o=0, last_idx=SRC_CNT-1, so source 0 has highest priority first.
  - busy_o=0, pkt_o.tvalid=0, all pkt_i[k].tready=0.
- IDLE:
  - pkt_o.tvalid=0 and all tready=0.
  - If any request exists, pick the first requester searching from last_idx+1 upward, modulo SRC_CNT.
  - Register the pick into grant_idx_o and last_idx; go to BUSY next cycle. Arbitration latency is 1 cycle.
- BUSY (g = grant_idx_o):
  - Combinational pass-through: pkt_o.{tvalid,tdata,tkeep,tstrb,tlast,tid,tdest,tuser} = pkt_i[g].*
  - pkt_i[g].tready = pkt_o.tready; pkt_i[k≠g].tready = 0.
  - busy_o = 1.
- End of packet: tx handshake with tlast=1 re-arbitrates in the same cycle.
  - Candidates are requesters excluding g, searched from g+1.
  - If a candidate exists: stay BUSY, load the new grant, and its first beat can be presented next cycle. There is no bubble beyond that cycle.
  - If no candidate exists: go to IDLE.
  - So a source never wins twice in a row while others request.
- src_en_i clear on the granted source mid-packet does not abort the packet; it takes effect at the next arbitration.
- Idle mid-packet (tvalid low on the owner) holds the grant indefinitely; there is no timeout.
- Single requester streaming packets back-to-back: each packet ends with BUSY→IDLE→BUSY, i.e. one dead cycle per packet.
- Reset asserted mid-packet: immediately returns to reset state. Partial packet downstream is the system's responsibility.
- No data registers in the datapath. All outputs other than the pass-through fields are flop outputs.

Optional Feature:
- Macro: AXI4_STREAM_ARB_TID_TAG_EN.
- Defined:
  - pkt_o.tid = zero-extended grant_idx_o instead of pkt_i[g].tid.
  - Elaboration error if TID_WIDTH < SRC_CNT_W.
  - Downstream can demultiplex responses by source.
- Undefined: tid passes through unchanged, with no width check.

Decomposition:
- Package axi4_stream_arb_pkg holds:
  - enum arb_state_t {IDLE, BUSY};
  - function rr_pick(req vector, start index) returning found flag + index;
  - constant MAX_SRC_CNT=16.
- One sub-module is natural: rr_priority_picker. It is combinational, taking a request vector and start pointer and returning valid + index. It is used for both the IDLE pick and the tlast pick.

Test Plan:
- Single source 2, src_en_i=4'hF, packet of 3 beats → grant_idx_o=2 one cycle after tvalid; output beats identical to input; busy_o falls the cycle after tlast.
- Sources 0,1,3 each hold a 2-beat packet continuously → output packet order 0,1,3,0,1,3; never interleaved; no idle cycle between packets.
- Random pkt_o.tready at 50% during a 5-beat packet from source 1 → no beat lost or duplicated; other sources' tready stays 0 throughout.
- src_en_i=4'b1101 with sources 0,1 requesting → only source 0 is granted. Clearing bit 0 mid-packet lets the packet finish; source 0 is not regranted afterwards.
- Reset low for 1 cycle during beat 2 of 4 → next cycle busy_o=0, grant_idx_o=0, pkt_o.tvalid=0; then source 0 wins the first arbitration.
- With AXI4_STREAM_ARB_TID_TAG_EN, TID_WIDTH=2, source 3 sends tid=0 → pkt_o.tid=3 on every beat.

Source files
------------

// File: rtl/axi4_stream_arb_pkg.sv
// Shared types and the round-robin search used by the AXI4-Stream packet arbiter.
// Optional build macro honoured by the arbiter: AXI4_STREAM_ARB_TID_TAG_EN.
package axi4_stream_arb_pkg;

    localparam int MAX_SRC_CNT = 16;
    localparam int MAX_SRC_W   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                 found;
        logic [MAX_SRC_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req at or after start, wrapping at cnt; descending loop so the
    // closest position to start is the last one written.
    function automatic rr_pick_t rr_pick(input logic [MAX_SRC_CNT-1:0] req,
                                         input logic [MAX_SRC_W-1:0]   start,
                                         input int                     cnt);
        rr_pick_t           res;
        logic [MAX_SRC_W:0] pos;
        res = '0;
        for (int i = MAX_SRC_CNT - 1; i >= 0; i--) begin
            if (i < cnt) begin
                pos = {1'b0, start} + (MAX_SRC_W + 1)'(i);
                if (pos >= (MAX_SRC_W + 1)'(cnt)) begin
                    pos = pos - (MAX_SRC_W + 1)'(cnt);
                end
                if (req[pos[MAX_SRC_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = pos[MAX_SRC_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi4_stream_rr_arbiter_picker.sv
// Combinational round-robin picker: first requester at or after start, modulo SRC_CNT.
module rr_priority_picker
    import axi4_stream_arb_pkg::*;
#(
    parameter int SRC_CNT   = 4,
    parameter int SRC_CNT_W = 2
) (
    input  logic [SRC_CNT-1:0]   req,
    input  logic [SRC_CNT_W-1:0] start,
    output logic                 valid,
    output logic [SRC_CNT_W-1:0] idx
);

    logic [MAX_SRC_CNT-1:0] req_ext;
    rr_pick_t               pick;

    always_comb begin
        req_ext                = '0;
        req_ext[SRC_CNT-1:0]   = req;
        pick                   = rr_pick(req_ext, MAX_SRC_W'(start), SRC_CNT);
    end

    assign valid = pick.found;
    assign idx   = SRC_CNT_W'(pick.idx);

endmodule

// File: rtl/axi4_stream_rr_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI4-Stream output among SRC_CNT sources.
// Define AXI4_STREAM_ARB_TID_TAG_EN to replace output tid with the granted source index.
module axi4_stream_rr_arbiter
    import axi4_stream_arb_pkg::*;
#(
    parameter int SRC_CNT     = 4,
    parameter int TDATA_WIDTH = 64,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    localparam int SRC_CNT_W  = (SRC_CNT > 1) ? $clog2(SRC_CNT) : 1,
    localparam int KEEP_W     = TDATA_WIDTH / 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [SRC_CNT-1:0]               src_en_i,
    input  logic [SRC_CNT-1:0]               pkt_i_tvalid,
    output logic [SRC_CNT-1:0]               pkt_i_tready,
    input  logic [SRC_CNT*TDATA_WIDTH-1:0]   pkt_i_tdata,
    input  logic [SRC_CNT*KEEP_W-1:0]        pkt_i_tkeep,
    input  logic [SRC_CNT*KEEP_W-1:0]        pkt_i_tstrb,
    input  logic [SRC_CNT-1:0]               pkt_i_tlast,
    input  logic [SRC_CNT*TID_WIDTH-1:0]     pkt_i_tid,
    input  logic [SRC_CNT*TDEST_WIDTH-1:0]   pkt_i_tdest,
    input  logic [SRC_CNT*TUSER_WIDTH-1:0]   pkt_i_tuser,
    output logic                             pkt_o_tvalid,
    input  logic                             pkt_o_tready,
    output logic [TDATA_WIDTH-1:0]           pkt_o_tdata,
    output logic [KEEP_W-1:0]                pkt_o_tkeep,
    output logic [KEEP_W-1:0]                pkt_o_tstrb,
    output logic                             pkt_o_tlast,
    output logic [TID_WIDTH-1:0]             pkt_o_tid,
    output logic [TDEST_WIDTH-1:0]           pkt_o_tdest,
    output logic [TUSER_WIDTH-1:0]           pkt_o_tuser,
    output logic [SRC_CNT_W-1:0]             grant_idx_o,
    output logic                             busy_o
);

    if (SRC_CNT < 2 || SRC_CNT > MAX_SRC_CNT) begin : g_src_cnt_check
        $error("axi4_stream_rr_arbiter: SRC_CNT must be in 2..16");
    end

    arb_state_t             state_reg;
    logic [SRC_CNT_W-1:0]   grant_reg;
    logic [SRC_CNT_W-1:0]   last_reg;
    logic                   busy_reg;

    logic [TDATA_WIDTH-1:0] tdata_arr [SRC_CNT];
    logic [KEEP_W-1:0]      tkeep_arr [SRC_CNT];
    logic [KEEP_W-1:0]      tstrb_arr [SRC_CNT];
    logic [TDEST_WIDTH-1:0] tdest_arr [SRC_CNT];
    logic [TUSER_WIDTH-1:0] tuser_arr [SRC_CNT];
    logic [SRC_CNT-1:0]     grant_onehot;

    for (genvar gi = 0; gi < SRC_CNT; gi++) begin : g_src
        assign tdata_arr[gi]    = pkt_i_tdata[gi*TDATA_WIDTH +: TDATA_WIDTH];
        assign tkeep_arr[gi]    = pkt_i_tkeep[gi*KEEP_W +: KEEP_W];
        assign tstrb_arr[gi]    = pkt_i_tstrb[gi*KEEP_W +: KEEP_W];
        assign tdest_arr[gi]    = pkt_i_tdest[gi*TDEST_WIDTH +: TDEST_WIDTH];
        assign tuser_arr[gi]    = pkt_i_tuser[gi*TUSER_WIDTH +: TUSER_WIDTH];
        assign grant_onehot[gi] = (grant_reg == SRC_CNT_W'(gi));
        assign pkt_i_tready[gi] = busy_reg & grant_onehot[gi] & pkt_o_tready;
    end

    assign pkt_o_tvalid = busy_reg & pkt_i_tvalid[grant_reg];
    assign pkt_o_tdata  = tdata_arr[grant_reg];
    assign pkt_o_tkeep  = tkeep_arr[grant_reg];
    assign pkt_o_tstrb  = tstrb_arr[grant_reg];
    assign pkt_o_tlast  = pkt_i_tlast[grant_reg];
    assign pkt_o_tdest  = tdest_arr[grant_reg];
    assign pkt_o_tuser  = tuser_arr[grant_reg];

`ifdef AXI4_STREAM_ARB_TID_TAG_EN
    if (TID_WIDTH < SRC_CNT_W) begin : g_tid_width_check
        $error("axi4_stream_rr_arbiter: TID_WIDTH too narrow to carry the source index");
    end
    assign pkt_o_tid = TID_WIDTH'(grant_reg);
`else
    logic [TID_WIDTH-1:0] tid_arr [SRC_CNT];
    for (genvar gi = 0; gi < SRC_CNT; gi++) begin : g_tid
        assign tid_arr[gi] = pkt_i_tid[gi*TID_WIDTH +: TID_WIDTH];
    end
    assign pkt_o_tid = tid_arr[grant_reg];
`endif

    assign grant_idx_o = grant_reg;
    assign busy_o      = busy_reg;

    logic [SRC_CNT-1:0]   req;
    logic [SRC_CNT-1:0]   pick_req;
    logic [SRC_CNT_W-1:0] start_ptr;
    logic                 pick_valid;
    logic [SRC_CNT_W-1:0] pick_idx;
    logic                 tx_last;

    // While busy last_reg equals the owner, so one picker serves both the idle pick
    // and the end-of-packet pick; only the owner's own request has to be masked.
    assign req       = pkt_i_tvalid & src_en_i;
    assign pick_req  = busy_reg ? (req & ~grant_onehot) : req;
    assign start_ptr = (last_reg == SRC_CNT_W'(SRC_CNT - 1)) ? '0 : last_reg + 1'b1;
    assign tx_last   = pkt_o_tvalid & pkt_o_tready & pkt_o_tlast;

    rr_priority_picker #(
        .SRC_CNT   (SRC_CNT),
        .SRC_CNT_W (SRC_CNT_W)
    ) u_picker (
        .req   (pick_req),
        .start (start_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            last_reg  <= SRC_CNT_W'(SRC_CNT - 1);
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        grant_reg <= pick_idx;
                        last_reg  <= pick_idx;
                        busy_reg  <= 1'b1;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (tx_last) begin
                        if (pick_valid) begin
                            grant_reg <= pick_idx;
                            last_reg  <= pick_idx;
                        end else begin
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
